// File: rtl/morse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : morse_pkg                                                    |
// | Description : Shared Morse types, timing constants and code constructor    |
// |               for the encoder and decoder paths.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package morse_pkg;

    // pattern is right-aligned: bit len-1 is the first element, 1 = dash
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pattern;
    } morse_code_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MARK     = 3'd1,
        ST_ELEM_GAP = 3'd2,
        ST_CHAR_GAP = 3'd3,
        ST_WORD_GAP = 3'd4,
        ST_ERR      = 3'd5
    } morse_state_e;

    localparam int unsigned DOT_UNITS        = 1;
    localparam int unsigned DASH_UNITS       = 3;
    localparam int unsigned ELEM_GAP_UNITS   = 1;
    localparam int unsigned CHAR_GAP_UNITS   = 3;
    localparam int unsigned WORD_EXTRA_UNITS = 4;
    localparam logic [7:0]  ASCII_SPACE      = 8'h20;

    function automatic morse_code_t mk_code(input logic [2:0] len, input logic [4:0] pat);
        morse_code_t c;
        c.len     = len;
        c.pattern = pat;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/morse_lut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : morse_lut                                                    |
// | Description : Combinational ASCII to International Morse code lookup.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module morse_lut
    import morse_pkg::*;
(
    input  logic [7:0]  i_ascii,
    output logic        o_supported,
    output logic        o_is_space,
    output morse_code_t o_code
);

    logic [7:0] w_upper;

    always_comb begin
        w_upper     = (i_ascii >= 8'h61 && i_ascii <= 8'h7A) ? (i_ascii - 8'h20) : i_ascii;
        o_supported = 1'b1;
        o_is_space  = 1'b0;
        o_code      = mk_code(3'd0, 5'b00000);
        case (w_upper)
            ASCII_SPACE: o_is_space = 1'b1;
            8'h41: o_code = mk_code(3'd2, 5'b00001); // A .-
            8'h42: o_code = mk_code(3'd4, 5'b01000); // B -...
            8'h43: o_code = mk_code(3'd4, 5'b01010); // C -.-.
            8'h44: o_code = mk_code(3'd3, 5'b00100); // D -..
            8'h45: o_code = mk_code(3'd1, 5'b00000); // E .
            8'h46: o_code = mk_code(3'd4, 5'b00010); // F ..-.
            8'h47: o_code = mk_code(3'd3, 5'b00110); // G --.
            8'h48: o_code = mk_code(3'd4, 5'b00000); // H ....
            8'h49: o_code = mk_code(3'd2, 5'b00000); // I ..
            8'h4A: o_code = mk_code(3'd4, 5'b00111); // J .---
            8'h4B: o_code = mk_code(3'd3, 5'b00101); // K -.-
            8'h4C: o_code = mk_code(3'd4, 5'b00100); // L .-..
            8'h4D: o_code = mk_code(3'd2, 5'b00011); // M --
            8'h4E: o_code = mk_code(3'd2, 5'b00010); // N -.
            8'h4F: o_code = mk_code(3'd3, 5'b00111); // O ---
            8'h50: o_code = mk_code(3'd4, 5'b00110); // P .--.
            8'h51: o_code = mk_code(3'd4, 5'b01101); // Q --.-
            8'h52: o_code = mk_code(3'd3, 5'b00010); // R .-.
            8'h53: o_code = mk_code(3'd3, 5'b00000); // S ...
            8'h54: o_code = mk_code(3'd1, 5'b00001); // T -
            8'h55: o_code = mk_code(3'd3, 5'b00001); // U ..-
            8'h56: o_code = mk_code(3'd4, 5'b00001); // V ...-
            8'h57: o_code = mk_code(3'd3, 5'b00011); // W .--
            8'h58: o_code = mk_code(3'd4, 5'b01001); // X -..-
            8'h59: o_code = mk_code(3'd4, 5'b01011); // Y -.--
            8'h5A: o_code = mk_code(3'd4, 5'b01100); // Z --..
            8'h30: o_code = mk_code(3'd5, 5'b11111);
            8'h31: o_code = mk_code(3'd5, 5'b01111);
            8'h32: o_code = mk_code(3'd5, 5'b00111);
            8'h33: o_code = mk_code(3'd5, 5'b00011);
            8'h34: o_code = mk_code(3'd5, 5'b00001);
            8'h35: o_code = mk_code(3'd5, 5'b00000);
            8'h36: o_code = mk_code(3'd5, 5'b10000);
            8'h37: o_code = mk_code(3'd5, 5'b11000);
            8'h38: o_code = mk_code(3'd5, 5'b11100);
            8'h39: o_code = mk_code(3'd5, 5'b11110);
            default: o_supported = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/morse_encoder_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : morse_encoder_tx                                             |
// | Description : ASCII to Morse key-line transmitter with valid/ready input.  |
// |               Optional sidetone output enabled by MORSE_TX_SIDETONE_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module morse_encoder_tx
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CLKS      = 5_000_000,
    parameter int unsigned TONE_HALF_CLKS = 50_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] char_i,
    input  logic       char_valid_i,
    output logic       char_ready_o,
    output logic       key_o,
    output logic       busy_o,
    output logic       err_o,
    output logic       tone_o
);

    localparam int unsigned         c_CNT_W    = (UNIT_CLKS > 1) ? $clog2(UNIT_CLKS) : 1;
    localparam logic [c_CNT_W-1:0] c_CLK_LAST = c_CNT_W'(UNIT_CLKS - 1);
    localparam logic [c_CNT_W-1:0] c_CLK_PEN  = c_CNT_W'((UNIT_CLKS > 1) ? (UNIT_CLKS - 2) : 0);

    if (UNIT_CLKS < 1 || TONE_HALF_CLKS < 1) begin : g_param_check
        $error("morse_encoder_tx: UNIT_CLKS and TONE_HALF_CLKS must be >= 1");
    end

    morse_state_e        r_state, w_state_next;
    logic [c_CNT_W-1:0]  r_clk_cnt;
    logic [1:0]          r_unit_cnt;
    logic [2:0]          r_elem_idx;
    logic [2:0]          r_len;
    logic [4:0]          r_shift;

    logic                w_supported, w_is_space, w_accept;
    logic                w_unit_done, w_mark_done, w_last_elem;
    morse_code_t         w_code;

    morse_lut u_lut (
        .i_ascii     (char_i),
        .o_supported (w_supported),
        .o_is_space  (w_is_space),
        .o_code      (w_code)
    );

    // The trailing gap ends one cycle early: the IDLE/accept cycle supplies the
    // last key-up clock, so streamed characters keep exact unit spacing.
    function automatic logic final_gap_done(input logic [1:0] unit, input logic [c_CNT_W-1:0] cnt,
                                            input int unsigned units);
        if (UNIT_CLKS == 1) return unit == 2'(units - 2);
        else                return (unit == 2'(units - 1)) && (cnt == c_CLK_PEN);
    endfunction

    assign w_accept    = char_valid_i && (r_state == ST_IDLE);
    assign w_unit_done = (r_clk_cnt == c_CLK_LAST);
    assign w_mark_done = w_unit_done &&
                         (r_shift[4] ? (r_unit_cnt == 2'(DASH_UNITS - 1)) : (r_unit_cnt == 2'(DOT_UNITS - 1)));
    assign w_last_elem = (r_elem_idx == (r_len - 3'd1));

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_supported)   w_state_next = ST_ERR;
                    else if (w_is_space) w_state_next = ST_WORD_GAP;
                    else                 w_state_next = ST_MARK;
                end
            end
            ST_MARK: begin
                if (w_mark_done) w_state_next = w_last_elem ? ST_CHAR_GAP : ST_ELEM_GAP;
            end
            ST_ELEM_GAP: begin
                if (w_unit_done && r_unit_cnt == 2'(ELEM_GAP_UNITS - 1)) w_state_next = ST_MARK;
            end
            ST_CHAR_GAP: begin
                if (final_gap_done(r_unit_cnt, r_clk_cnt, CHAR_GAP_UNITS)) w_state_next = ST_IDLE;
            end
            ST_WORD_GAP: begin
                if (final_gap_done(r_unit_cnt, r_clk_cnt, WORD_EXTRA_UNITS)) w_state_next = ST_IDLE;
            end
            ST_ERR:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        char_ready_o = (r_state == ST_IDLE);
        busy_o       = (r_state != ST_IDLE);
        key_o        = (r_state == ST_MARK);
        err_o        = (r_state == ST_ERR);
    end

    // Timing counters restart on every state change
    always_ff @(posedge clk) begin
        if (!resetn || (w_state_next != r_state) || (r_state == ST_IDLE)) begin
            r_clk_cnt  <= '0;
            r_unit_cnt <= 2'd0;
        end else if (w_unit_done) begin
            r_clk_cnt  <= '0;
            r_unit_cnt <= r_unit_cnt + 2'd1;
        end else begin
            r_clk_cnt  <= r_clk_cnt + c_CNT_W'(1);
        end
    end

    // Pattern is left-aligned at capture so the current element is always r_shift[4]
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_shift    <= 5'b00000;
            r_len      <= 3'd0;
            r_elem_idx <= 3'd0;
        end else if (w_accept) begin
            r_shift    <= w_code.pattern << (3'd5 - w_code.len);
            r_len      <= w_code.len;
            r_elem_idx <= 3'd0;
        end else if (r_state == ST_ELEM_GAP && w_state_next == ST_MARK) begin
            r_shift    <= {r_shift[3:0], 1'b0};
            r_elem_idx <= r_elem_idx + 3'd1;
        end
    end

`ifdef MORSE_TX_SIDETONE_EN
    localparam int unsigned               c_TONE_W    = (TONE_HALF_CLKS > 1) ? $clog2(TONE_HALF_CLKS) : 1;
    localparam logic [c_TONE_W-1:0]      c_TONE_LAST = c_TONE_W'(TONE_HALF_CLKS - 1);

    logic                r_tone;
    logic [c_TONE_W-1:0] r_tone_cnt;
    logic                w_key_next;

    assign w_key_next = (w_state_next == ST_MARK);

    always_ff @(posedge clk) begin
        if (!resetn || !w_key_next) begin
            r_tone     <= 1'b0;
            r_tone_cnt <= '0;
        end else if (!key_o) begin
            r_tone     <= 1'b1;
            r_tone_cnt <= '0;
        end else if (r_tone_cnt == c_TONE_LAST) begin
            r_tone     <= ~r_tone;
            r_tone_cnt <= '0;
        end else begin
            r_tone_cnt <= r_tone_cnt + c_TONE_W'(1);
        end
    end

    assign tone_o = key_o & r_tone;
`else
    assign tone_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_morse_encoder_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_morse_encoder_tx                                          |
// | Description : Directed self-checking bench for morse_encoder_tx, UNIT=4.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_morse_encoder_tx;

    localparam int unsigned c_UNIT = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] char_i;
    logic       char_valid_i;
    logic       char_ready_o, key_o, busy_o, err_o, tone_o;

    int checks   = 0;
    int failures = 0;

    logic [63:0] key_tr, rdy_tr, busy_tr, err_tr, tone_tr;
    logic [63:0] e1_key;

    morse_encoder_tx #(
        .UNIT_CLKS      (c_UNIT),
        .TONE_HALF_CLKS (1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .char_i       (char_i),
        .char_valid_i (char_valid_i),
        .char_ready_o (char_ready_o),
        .key_o        (key_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .tone_o       (tone_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns just after the accepting posedge
    task automatic send(input logic [7:0] ch, input bit hold);
        int n;
        char_i       = ch;
        char_valid_i = 1'b1;
        n = 0;
        while (!char_ready_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            failures++;
            $display("FAIL send_timeout observed=ready_low expected=ready_high");
        end
        @(posedge clk);
        if (!hold) #1 char_valid_i = 1'b0;
    endtask

    // Bit i of each trace holds the sample taken i+1 cycles after acceptance
    task automatic capture(input int n, input bit drop_valid);
        key_tr = '0; rdy_tr = '0; busy_tr = '0; err_tr = '0; tone_tr = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (drop_valid && i == 0) char_valid_i = 1'b0;
            key_tr[i]  = key_o;
            rdy_tr[i]  = char_ready_o;
            busy_tr[i] = busy_o;
            err_tr[i]  = err_o;
            tone_tr[i] = tone_o;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        resetn       = 1'b0;
        char_i       = 8'h00;
        char_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, char_ready_o}, 64'd1);
        chk("rst_outs",  {60'd0, key_o, busy_o, err_o, tone_o}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // 'E': one dot then the character gap
        send("E", 1'b0);
        capture(16, 1'b0);
        chk("E_key",  key_tr,  64'h0000_000F);
        chk("E_rdy",  rdy_tr,  64'h0000_8000);
        chk("E_busy", busy_tr, 64'h0000_7FFF);
        chk("E_err",  err_tr,  64'h0);

        // 'A' then 'a' streamed with valid held high
        send("A", 1'b1);
        capture(32, 1'b0);
        chk("A_key", key_tr, 64'h0000_0000_000F_FF0F);
        chk("A_rdy", rdy_tr, 64'h0000_0000_8000_0000);
        char_i = "a";
        capture(32, 1'b1);
        chk("a_key", key_tr, 64'h0000_0000_000F_FF0F);
        chk("a_rdy", rdy_tr, 64'h0000_0000_8000_0000);

        // "E E": word spacing
        send("E", 1'b0);
        capture(16, 1'b0);
        e1_key = key_tr;
        send(8'h20, 1'b0);
        capture(16, 1'b0);
        chk("sp_key", key_tr, 64'h0);
        chk("sp_rdy", rdy_tr, 64'h0000_8000);
        gap = (16 - $countones(e1_key)) + (16 - $countones(key_tr));
        send("E", 1'b0);
        capture(16, 1'b0);
        chk("E2_key", key_tr, 64'h0000_000F);
        chk("word_gap", 64'(gap), 64'd28);

        // unsupported character
        send(8'h23, 1'b0);
        capture(2, 1'b0);
        chk("hash_err", err_tr, 64'h1);
        chk("hash_key", key_tr, 64'h0);
        chk("hash_rdy", rdy_tr, 64'h2);

        // 'O' interrupted by reset in the second dash
        send("O", 1'b0);
        capture(20, 1'b0);
        chk("O_key", key_tr, 64'h0000_0000_000F_0FFF);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_key",  {63'd0, key_o}, 64'd0);
        chk("abort_rdy",  {62'd0, char_ready_o, busy_o}, 64'd2);
        resetn = 1'b1;

        send("t", 1'b0);
        capture(24, 1'b0);
        chk("T_key", key_tr, 64'h0000_0000_0000_0FFF);
        chk("T_rdy", rdy_tr, 64'h0000_0000_0080_0000);
`ifdef MORSE_TX_SIDETONE_EN
        chk("T_tone", tone_tr, 64'h0000_0000_0000_0555);
`else
        chk("T_tone", tone_tr, 64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
